// File: rtl/mult_sched_if.sv
// Requester-side bus of the mult_sched multiplier scheduler.
// master = requester side, slave = scheduler side.
interface mult_sched_if #(
    parameter int unsigned NREQ = 4
) ();
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] req_mplier;
    logic [4*NREQ-1:0] req_mcand;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [6:0]        rsp_product;
    logic              rsp_err;

    modport master (
        output req, req_mplier, req_mcand,
        input  gnt, rsp_valid, rsp_product, rsp_err
    );

    modport slave (
        input  req, req_mplier, req_mcand,
        output gnt, rsp_valid, rsp_product, rsp_err
    );
endinterface

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one sequential 4x4 signed multiplier among NREQ requesters.
// Optional BUSY timeout with error response: define MULT_SCHED_TIMEOUT_EN.
module mult_sched #(
    parameter int unsigned NREQ = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    mult_sched_if.slave       bus,
    output logic              mul_St,
    output logic [3:0]        mul_Mplier,
    output logic [3:0]        mul_Mcand,
    input  logic [6:0]        mul_Product,
    input  logic              mul_Done
);
    localparam int unsigned IDXW        = $clog2(NREQ);
    localparam int unsigned INIT_CYCLES = 6;

    typedef enum logic [2:0] {INIT, IDLE, START, BUSY, RESP} state_t;

    state_t            state, state_d;
    logic [2:0]        cnt, cnt_d;          // INIT flush count, BUSY timeout count
    logic [IDXW-1:0]   last_winner, last_winner_d;
    logic [IDXW-1:0]   pick;
    logic [IDXW+1:0]   op_base;
    logic              any_req;

    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [6:0]        rsp_product_q, rsp_product_d;
    logic              mul_st_q, mul_st_d;
    logic [3:0]        mplier_q, mplier_d;
    logic [3:0]        mcand_q, mcand_d;
`ifdef MULT_SCHED_TIMEOUT_EN
    logic              rsp_err_q, rsp_err_d;
`endif

    function automatic logic [IDXW-1:0] rr_idx(input logic [IDXW-1:0] base, input int unsigned k);
        return IDXW'((32'(base) + k) % NREQ);
    endfunction

    // Round-robin winner: first requester after last_winner, wrapping modulo NREQ
    always_comb begin
        any_req = |bus.req;
        pick    = last_winner;
        for (int unsigned k = NREQ; k > 0; k--) begin
            if (bus.req[rr_idx(last_winner, k)]) begin
                pick = rr_idx(last_winner, k);
            end
        end
        op_base = {pick, 2'b00};
    end

    // Next-state and registered-output values
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        last_winner_d = last_winner;
        gnt_d         = gnt_q;
        rsp_valid_d   = '0;
        rsp_product_d = rsp_product_q;
        mul_st_d      = 1'b0;
        mplier_d      = mplier_q;
        mcand_d       = mcand_q;
`ifdef MULT_SCHED_TIMEOUT_EN
        rsp_err_d     = 1'b0;
`endif
        case (state)
            INIT: begin
                cnt_d = cnt + 3'd1;
                if (cnt == 3'(INIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (any_req) begin
                    gnt_d         = '0;
                    gnt_d[pick]   = 1'b1;
                    last_winner_d = pick;
                    mplier_d      = bus.req_mplier[op_base +: 4];
                    mcand_d       = bus.req_mcand[op_base +: 4];
                    mul_st_d      = 1'b1;
                    state_d       = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                if (mul_Done) begin
                    rsp_product_d = mul_Product;
                    rsp_valid_d   = gnt_q;
                    state_d       = RESP;
                end
`ifdef MULT_SCHED_TIMEOUT_EN
                else if (cnt == 3'd7) begin
                    rsp_product_d = '0;
                    rsp_valid_d   = gnt_q;
                    rsp_err_d     = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt + 3'd1;
                end
`endif
            end
            RESP: begin
                gnt_d = '0;
                cnt_d = '0;
`ifdef MULT_SCHED_TIMEOUT_EN
                // A timed-out multiplier may be wedged; flush it again
                state_d = rsp_err_q ? INIT : IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= INIT;
            cnt         <= '0;
            last_winner <= IDXW'(NREQ - 1);
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            last_winner <= last_winner_d;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_product_q <= '0;
            mul_st_q      <= 1'b0;
            mplier_q      <= '0;
            mcand_q       <= '0;
        end else begin
            gnt_q         <= gnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_product_q <= rsp_product_d;
            mul_st_q      <= mul_st_d;
            mplier_q      <= mplier_d;
            mcand_q       <= mcand_d;
        end
    end

`ifdef MULT_SCHED_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.gnt         = gnt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_product = rsp_product_q;
    assign mul_St          = mul_st_q;
    assign mul_Mplier      = mplier_q;
    assign mul_Mcand       = mcand_q;
endmodule
